// File: rtl/branch_pkg.sv
// Shared branch definitions: kind codes, default queue depth and
// small arithmetic helpers used by the decoder and the resolve block.
package branch_pkg;

  localparam int DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    K_BEQ    = 3'd0,
    K_BGEZ   = 3'd1,
    K_BGEZAL = 3'd2,
    K_BGTZ   = 3'd3,
    K_BLEZ   = 3'd4,
    K_BLTZ   = 3'd5,
    K_BLTZAL = 3'd6,
    K_RSVD   = 3'd7
  } br_kind_e;

  // Link-writing kinds deposit pc+8 into the link register.
  function automatic logic is_link(input logic [2:0] kind);
    logic r;
    case (kind)
      K_BGEZAL: r = 1'b1;
      K_BLTZAL: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // Taken target: pc + 4 + sign-extended word offset, wrapping at 2^32.
  function automatic logic [31:0] br_target(input logic [31:0] pc,
                                            input logic [15:0] off);
    return pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Pure combinational branch condition evaluation (signed compares).
import branch_pkg::*;

module branch_cond (
  input  logic [2:0]  i_kind,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_taken
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = i_rs[31];
  assign w_rs_zero = (i_rs == 32'd0);

  // Select the outcome for the branch kind; reserved code never branches.
  always_comb begin
    o_taken = 1'b0;
    case (i_kind)
      K_BEQ:    o_taken = (i_rs == i_rt);
      K_BGEZ:   o_taken = ~w_rs_neg;
      K_BGEZAL: o_taken = ~w_rs_neg;
      K_BGTZ:   o_taken = ~w_rs_neg & ~w_rs_zero;
      K_BLEZ:   o_taken = w_rs_neg | w_rs_zero;
      K_BLTZ:   o_taken = w_rs_neg;
      K_BLTZAL: o_taken = w_rs_neg;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// In-order branch resolution queue: allocates decoded branches, collects
// operands out of order, resolves the head one per cycle and raises a
// redirect + flush on mispredict.
import branch_pkg::*;

module branch_resolve #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_kind,
  input  logic [31:0]              in_pc,
  input  logic [15:0]              in_offset,
  input  logic                     in_pred_taken,
  output logic [$clog2(DEPTH)-1:0] in_tag,
  input  logic                     opnd_valid,
  input  logic [$clog2(DEPTH)-1:0] opnd_tag,
  input  logic [31:0]              opnd_rs,
  input  logic [31:0]              opnd_rt,
  output logic                     res_valid,
  output logic [$clog2(DEPTH)-1:0] res_tag,
  output logic                     res_taken,
  output logic [31:0]              res_link,
  output logic                     res_link_we,
  output logic                     redir_valid,
  input  logic                     redir_ready,
  output logic [31:0]              redir_pc,
  output logic                     flush
);

  localparam int TW = $clog2(DEPTH);
  localparam logic [TW:0] LP_DEPTH = DEPTH[TW:0];

  // Per-entry state
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_opv;
  logic [2:0]       r_kind [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [15:0]      r_off  [DEPTH];
  logic             r_pred [DEPTH];
  logic [31:0]      r_rs   [DEPTH];
  logic [31:0]      r_rt   [DEPTH];

  logic [TW-1:0] r_head;
  logic [TW-1:0] r_tail;
  logic [TW:0]   r_count;

  logic          r_res_valid;
  logic [TW-1:0] r_res_tag;
  logic          r_res_taken;
  logic [31:0]   r_res_link;
  logic          r_res_link_we;
  logic          r_redir_valid;
  logic [31:0]   r_redir_pc;
  logic          r_flush;

  logic w_accept;
  logic w_resolve;
  logic w_handshake;
  logic w_opnd_ok;
  logic w_taken;

  assign in_ready    = (r_count < LP_DEPTH) & ~r_redir_valid;
  assign in_tag      = r_tail;
  assign w_accept    = in_valid & in_ready;
  assign w_handshake = r_redir_valid & redir_ready;
  assign w_resolve   = r_vld[r_head] & r_opv[r_head] & ~r_redir_valid;
  // Operands arriving while the queue is being squashed belong to dead ops.
  assign w_opnd_ok   = opnd_valid & r_vld[opnd_tag] & ~w_handshake & ~r_flush;

  branch_cond u_cond (
    .i_kind  (r_kind[r_head]),
    .i_rs    (r_rs[r_head]),
    .i_rt    (r_rt[r_head]),
    .o_taken (w_taken)
  );

  // Entry payload storage; contents are only meaningful under r_vld/r_opv.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind[r_tail] <= in_kind;
      r_pc[r_tail]   <= in_pc;
      r_off[r_tail]  <= in_offset;
      r_pred[r_tail] <= in_pred_taken;
    end
    if (w_opnd_ok) begin
      r_rs[opnd_tag] <= opnd_rs;
      r_rt[opnd_tag] <= opnd_rt;
    end
  end

  // Queue bookkeeping: allocate at tail, pop at head, squash on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_opv   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_handshake) begin
      r_vld   <= '0;
      r_opv   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_vld[r_tail] <= 1'b1;
        r_opv[r_tail] <= 1'b0;
        r_tail        <= r_tail + TW'(1);
      end
      if (w_opnd_ok) begin
        r_opv[opnd_tag] <= 1'b1;
      end
      // Pop after the operand write so a late redelivery cannot revive it.
      if (w_resolve) begin
        r_vld[r_head] <= 1'b0;
        r_opv[r_head] <= 1'b0;
        r_head        <= r_head + TW'(1);
      end
      r_count <= r_count + (TW+1)'(w_accept) - (TW+1)'(w_resolve);
    end
  end

  // Registered resolution results and redirect/flush handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid   <= 1'b0;
      r_res_tag     <= '0;
      r_res_taken   <= 1'b0;
      r_res_link    <= 32'd0;
      r_res_link_we <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'd0;
      r_flush       <= 1'b0;
    end else begin
      r_res_valid <= w_resolve;
      r_flush     <= w_handshake;
      if (w_resolve) begin
        r_res_tag     <= r_head;
        r_res_taken   <= w_taken;
        r_res_link    <= r_pc[r_head] + 32'd8;
        r_res_link_we <= is_link(r_kind[r_head]);
      end
      if (w_resolve && (w_taken != r_pred[r_head])) begin
        r_redir_valid <= 1'b1;
        r_redir_pc    <= w_taken ? br_target(r_pc[r_head], r_off[r_head])
                                 : (r_pc[r_head] + 32'd8);
      end else if (w_handshake) begin
        r_redir_valid <= 1'b0;
      end
    end
  end

  assign res_valid   = r_res_valid;
  assign res_tag     = r_res_tag;
  assign res_taken   = r_res_taken;
  assign res_link    = r_res_link;
  assign res_link_we = r_res_link_we;
  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;
  assign flush       = r_flush;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [31:0] in_pc;
  logic [15:0] in_offset;
  logic        in_pred_taken;
  logic [1:0]  in_tag;
  logic        opnd_valid;
  logic [1:0]  opnd_tag;
  logic [31:0] opnd_rs;
  logic [31:0] opnd_rt;
  logic        res_valid;
  logic [1:0]  res_tag;
  logic        res_taken;
  logic [31:0] res_link;
  logic        res_link_we;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush;

  int n_checks;
  int n_errors;

  branch_resolve #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_kind       (in_kind),
    .in_pc         (in_pc),
    .in_offset     (in_offset),
    .in_pred_taken (in_pred_taken),
    .in_tag        (in_tag),
    .opnd_valid    (opnd_valid),
    .opnd_tag      (opnd_tag),
    .opnd_rs       (opnd_rs),
    .opnd_rt       (opnd_rt),
    .res_valid     (res_valid),
    .res_tag       (res_tag),
    .res_taken     (res_taken),
    .res_link      (res_link),
    .res_link_we   (res_link_we),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [2:0] kind, input logic [31:0] pc,
                       input logic [15:0] off, input logic pred,
                       input logic [1:0] exp_tag);
    in_valid      = 1'b1;
    in_kind       = kind;
    in_pc         = pc;
    in_offset     = off;
    in_pred_taken = pred;
    check_val("alloc_ready", {31'd0, in_ready}, 32'd1);
    check_val("alloc_tag", {30'd0, in_tag}, {30'd0, exp_tag});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic opnd(input logic [1:0] tag, input logic [31:0] rs,
                      input logic [31:0] rt);
    opnd_valid = 1'b1;
    opnd_tag   = tag;
    opnd_rs    = rs;
    opnd_rt    = rt;
    tick();
    opnd_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_kind       = 3'd0;
    in_pc         = 32'd0;
    in_offset     = 16'd0;
    in_pred_taken = 1'b0;
    opnd_valid    = 1'b0;
    opnd_tag      = 2'd0;
    opnd_rs       = 32'd0;
    opnd_rt       = 32'd0;
    redir_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_val("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    check_val("rst_flush", {31'd0, flush}, 32'd0);
    check_val("rst_redir_pc", redir_pc, 32'd0);
    check_val("rst_res_link", res_link, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_in_tag", {30'd0, in_tag}, 32'd0);

    // BEQ correctly predicted taken
    alloc(3'd0, 32'h0040_0000, 16'h0004, 1'b1, 2'd0);
    opnd(2'd0, 32'd5, 32'd5);
    tick();
    check_val("beq_res_valid", {31'd0, res_valid}, 32'd1);
    check_val("beq_res_tag", {30'd0, res_tag}, 32'd0);
    check_val("beq_res_taken", {31'd0, res_taken}, 32'd1);
    check_val("beq_link_we", {31'd0, res_link_we}, 32'd0);
    check_val("beq_redir", {31'd0, redir_valid}, 32'd0);
    tick();
    check_val("beq_res_pulse", {31'd0, res_valid}, 32'd0);
    check_val("beq_flush", {31'd0, flush}, 32'd0);

    // BGEZ mispredicted not-taken, backward target, stalled redirect
    alloc(3'd1, 32'h0040_0010, 16'hFFFC, 1'b0, 2'd1);
    opnd(2'd1, 32'd0, 32'd0);
    tick();
    check_val("bgez_res_taken", {31'd0, res_taken}, 32'd1);
    check_val("bgez_redir_valid", {31'd0, redir_valid}, 32'd1);
    check_val("bgez_redir_pc", redir_pc, 32'h0040_0004);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bgez_hold_valid", {31'd0, redir_valid}, 32'd1);
      check_val("bgez_hold_pc", redir_pc, 32'h0040_0004);
      check_val("bgez_hold_ready", {31'd0, in_ready}, 32'd0);
      check_val("bgez_hold_flush", {31'd0, flush}, 32'd0);
    end
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check_val("bgez_redir_clr", {31'd0, redir_valid}, 32'd0);
    check_val("bgez_flush", {31'd0, flush}, 32'd1);
    check_val("bgez_empty_tag", {30'd0, in_tag}, 32'd0);
    check_val("bgez_empty_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_val("bgez_flush_pulse", {31'd0, flush}, 32'd0);

    // BLTZAL taken with link
    alloc(3'd6, 32'h0040_0020, 16'h0010, 1'b1, 2'd0);
    opnd(2'd0, 32'hFFFF_FFFF, 32'd0);
    tick();
    check_val("bltzal_valid", {31'd0, res_valid}, 32'd1);
    check_val("bltzal_taken", {31'd0, res_taken}, 32'd1);
    check_val("bltzal_link_we", {31'd0, res_link_we}, 32'd1);
    check_val("bltzal_link", res_link, 32'h0040_0028);
    check_val("bltzal_redir", {31'd0, redir_valid}, 32'd0);

    // BLEZ predicted taken but not taken: redirect to fall-through, ready already high
    alloc(3'd4, 32'h0040_0100, 16'h0040, 1'b1, 2'd1);
    redir_ready = 1'b1;
    opnd(2'd1, 32'd1, 32'd0);
    tick();
    check_val("blez_taken", {31'd0, res_taken}, 32'd0);
    check_val("blez_redir_valid", {31'd0, redir_valid}, 32'd1);
    check_val("blez_redir_pc", redir_pc, 32'h0040_0108);
    tick();
    redir_ready = 1'b0;
    check_val("blez_redir_clr", {31'd0, redir_valid}, 32'd0);
    check_val("blez_flush", {31'd0, flush}, 32'd1);

    // Fill the queue, operands in reverse order, resolve in order
    tick();
    alloc(3'd0, 32'h0040_0200, 16'h0001, 1'b1, 2'd0); // rs==rt taken
    alloc(3'd3, 32'h0040_0210, 16'h0001, 1'b0, 2'd1); // BGTZ rs=0 not taken
    alloc(3'd4, 32'h0040_0220, 16'h0001, 1'b1, 2'd2); // BLEZ rs=-1 taken
    alloc(3'd7, 32'h0040_0230, 16'h0001, 1'b0, 2'd3); // reserved not taken
    check_val("full_ready", {31'd0, in_ready}, 32'd0);
    opnd(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("full_wait3", {31'd0, res_valid}, 32'd0);
    opnd(2'd2, 32'hFFFF_FFFF, 32'd0);
    check_val("full_wait2", {31'd0, res_valid}, 32'd0);
    opnd(2'd1, 32'd0, 32'd0);
    check_val("full_wait1", {31'd0, res_valid}, 32'd0);
    opnd(2'd0, 32'd9, 32'd9);
    check_val("full_retire_ready", {31'd0, in_ready}, 32'd0);
    check_val("full_wait0", {31'd0, res_valid}, 32'd0);
    tick();
    check_val("q0_valid", {31'd0, res_valid}, 32'd1);
    check_val("q0_tag", {30'd0, res_tag}, 32'd0);
    check_val("q0_taken", {31'd0, res_taken}, 32'd1);
    tick();
    check_val("q1_valid", {31'd0, res_valid}, 32'd1);
    check_val("q1_tag", {30'd0, res_tag}, 32'd1);
    check_val("q1_taken", {31'd0, res_taken}, 32'd0);
    tick();
    check_val("q2_valid", {31'd0, res_valid}, 32'd1);
    check_val("q2_tag", {30'd0, res_tag}, 32'd2);
    check_val("q2_taken", {31'd0, res_taken}, 32'd1);
    tick();
    check_val("q3_valid", {31'd0, res_valid}, 32'd1);
    check_val("q3_tag", {30'd0, res_tag}, 32'd3);
    check_val("q3_taken", {31'd0, res_taken}, 32'd0);
    check_val("q3_link_we", {31'd0, res_link_we}, 32'd0);
    check_val("q3_redir", {31'd0, redir_valid}, 32'd0);
    tick();
    check_val("q_done", {31'd0, res_valid}, 32'd0);

    // Dropped delivery to an unallocated entry, then reset mid-redirect
    opnd(2'd0, 32'd7, 32'd7);
    alloc(3'd0, 32'h0040_1000, 16'h0008, 1'b0, 2'd0);
    alloc(3'd0, 32'h0040_1100, 16'h0008, 1'b0, 2'd1);
    alloc(3'd0, 32'h0040_1200, 16'h0008, 1'b0, 2'd2);
    check_val("drop_no_res", {31'd0, res_valid}, 32'd0);
    opnd(2'd0, 32'd7, 32'd7);
    tick();
    check_val("rr_taken", {31'd0, res_taken}, 32'd1);
    check_val("rr_redir_valid", {31'd0, redir_valid}, 32'd1);
    check_val("rr_redir_pc", redir_pc, 32'h0040_1024);
    check_val("rr_in_ready", {31'd0, in_ready}, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check_val("rr_async_redir", {31'd0, redir_valid}, 32'd0);
    check_val("rr_async_pc", redir_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rr_post_ready", {31'd0, in_ready}, 32'd1);
    check_val("rr_post_tag", {30'd0, in_tag}, 32'd0);
    opnd(2'd1, 32'd3, 32'd3);
    tick();
    check_val("rr_empty", {31'd0, res_valid}, 32'd0);
    check_val("rr_flush", {31'd0, flush}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning in-flight branch queue entries (power of two; tag width log2(DEPTH)).
REQ-002 SHALL have ports, in order:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  decoded branch offered
- in_ready  output  1  queue accepts branch
- in_kind  input  3  branch kind code
- in_pc  input  32  branch instruction PC
- in_offset  input  16  signed word offset
- in_pred_taken  input  1  fetch prediction
- in_tag  output  log2(DEPTH)  tag assigned to offered branch
- opnd_valid  input  1  operand delivery
- opnd_tag  input  log2(DEPTH)  target entry
- opnd_rs  input  32  rs value
- opnd_rt  input  32  rt value
- res_valid  output  1  one branch resolved this cycle
- res_tag  output  log2(DEPTH)  resolved entry
- res_taken  output  1  actual outcome
- res_link  output  32  in_pc+8 (valid for link kinds)
- res_link_we  output  1  kind is BGEZAL/BLTZAL
- redir_valid  output  1  mispredict redirect request
- redir_ready  input  1  fetch accepts redirect
- redir_pc  output  32  corrected fetch PC
- flush  output  1  one-cycle younger-op squash pulse

Function
REQ-003 SHALL encode kinds BEQ=0, BGEZ=1, BGEZAL=2, BGTZ=3, BLEZ=4, BLTZ=5, BLTZAL=6; code 7 SHALL be allocated and resolve not-taken, no link.
REQ-004 SHALL accept a branch when in_valid & in_ready, writing it at the tail; in_tag SHALL equal the tail index.
REQ-005 SHALL drive in_ready = (count < DEPTH) & ~redir_valid; a retire in the same cycle SHALL NOT enable acceptance into a full queue.
REQ-006 SHALL latch operands into the entry at opnd_tag when opnd_valid and that entry is allocated; otherwise the delivery SHALL be dropped; redelivery SHALL overwrite.
REQ-007 SHALL compare signed: BEQ rs==rt; BGEZ/BGEZAL rs>=0; BGTZ rs>0; BLEZ rs<=0; BLTZ/BLTZAL rs<0.
REQ-008 SHALL compute target = in_pc + 4 + (sign-extended offset << 2), modulo 2^32; fall-through = in_pc + 8 (delay slot).
REQ-009 SHALL resolve only the head entry, at most one per cycle, when its operands are present and redir_valid is low.
REQ-010 SHALL register results: head resolving in cycle N gives res_valid=1 with res_tag/res_taken/res_link/res_link_we in cycle N+1 for exactly one cycle; head pops in cycle N.
REQ-011 SHALL, when res_taken != pred_taken, set redir_valid in N+1 with redir_pc = taken ? target : fall-through, holding both stable until redir_ready.
REQ-012 SHALL, on the redir_valid & redir_ready cycle, empty the queue (all entries younger than the mispredicted branch), clear redir_valid, and pulse flush in the following cycle.
REQ-013 SHALL ignore opnd_valid in the redirect-handshake cycle and in the flush cycle.
REQ-014 SHALL wrap head/tail pointers modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-015 SHALL, on rst asserted asynchronously, clear all entry-valid and operand-present bits, head=tail=count=0, and drive res_valid=0, redir_valid=0, flush=0, res_tag=0, res_taken=0, res_link=0, res_link_we=0, redir_pc=0.
REQ-016 SHALL discard any pending redirect when rst asserts mid-handshake; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-017 SHALL place kind codes and DEPTH default in a shared package branch_pkg used by the decoder and this block.
REQ-018 SHALL instantiate one sub-module branch_cond (kind, rs, rt -> taken), purely combinational.

Verification
REQ-019 BEQ pc=0x00400000, offset=0x0004, rs=rt=5, pred_taken=1 -> res_taken=1, no redir_valid, no flush.
REQ-020 BGEZ pc=0x00400010, offset=0xFFFC, rs=0, pred_taken=0 -> redir_pc=0x00400004; with redir_ready low 3 cycles, redir_valid/redir_pc held, in_ready=0; flush one cycle after handshake; count=0.
REQ-021 BLTZAL pc=0x00400020, rs=0xFFFFFFFF, pred_taken=1 -> res_taken=1, res_link_we=1, res_link=0x00400028.
REQ-022 Allocate 4 branches, operands in order tag 3,2,1,0 -> in_ready=0 after fourth; resolves start the cycle after tag 0 arrives, in tag order 0,1,2,3, one per cycle.
REQ-023 rst pulse while redir_valid=1 with 2 entries queued -> redir_valid=0 immediately, count=0, in_ready=1 after release.
